// File: rtl/ifu_fetch_q.sv
// rtl/ifu_fetch_q.sv - instruction fetch front end: sequential PC generation, imem fetch, in-order queue to exu
// Optional zero-latency response bypass is enabled by defining IFU_BYPASS_EN.
module ifu_fetch_q #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_vld,
    input  logic        imem_req_rdy,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_vld,
    input  logic [31:0] imem_rsp_data,
    output logic        iexec_req_vld,
    input  logic        iexec_req_rdy,
    output logic [31:0] iexec_req_ir,
    output logic [31:0] iexec_req_pc,
    input  logic        redir_vld,
    input  logic [31:0] redir_pc
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    logic [31:0]   pc;
    logic          run;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [CW-1:0] count;
    logic [CW:0]   credit_sum;

    logic [31:0]   q_ir [DEPTH];
    logic [31:0]   q_pc [DEPTH];
    logic [PW-1:0] q_wr;
    logic [PW-1:0] q_rd;

    // pc of every accepted request, popped one per response (stale or not)
    logic [31:0]   f_pc [DEPTH];
    logic [PW-1:0] f_wr;
    logic [PW-1:0] f_rd;

    logic req_hsk;
    logic exec_hsk;
    logic rsp_keep;
    logic push;
    logic pop;
    logic bypass;

    assign credit_sum    = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_vld  = run && !redir_vld && (credit_sum < (CW+1)'(DEPTH));
    assign imem_req_addr = pc;
    assign req_hsk       = imem_req_vld && imem_req_rdy;
    assign rsp_keep      = imem_rsp_vld && (drop == '0) && !redir_vld;

`ifdef IFU_BYPASS_EN
    assign bypass = imem_rsp_vld && (count == '0) && (drop == '0) && !redir_vld;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        iexec_req_vld = 1'b0;
        iexec_req_ir  = 32'h0;
        iexec_req_pc  = 32'h0;
        if (count != '0) begin
            iexec_req_vld = 1'b1;
            iexec_req_ir  = q_ir[q_rd];
            iexec_req_pc  = q_pc[q_rd];
        end else if (bypass) begin
            iexec_req_vld = 1'b1;
            iexec_req_ir  = imem_rsp_data;
            iexec_req_pc  = f_pc[f_rd];
        end
    end

    assign exec_hsk = iexec_req_vld && iexec_req_rdy;
    assign pop      = exec_hsk && (count != '0);
    // a bypassed word consumed this cycle never occupies a slot
    assign push     = rsp_keep && !(bypass && iexec_req_rdy);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            run         <= 1'b0;
            outstanding <= '0;
            drop        <= '0;
            count       <= '0;
            q_wr        <= '0;
            q_rd        <= '0;
            f_wr        <= '0;
            f_rd        <= '0;
        end else begin
            run         <= 1'b1;
            outstanding <= outstanding + CW'(req_hsk) - CW'(imem_rsp_vld);
            if (req_hsk) begin
                f_wr <= f_wr + 1'b1;
            end
            if (imem_rsp_vld) begin
                f_rd <= f_rd + 1'b1;
            end

            if (redir_vld) begin
                pc    <= redir_pc & ~32'd3;
                drop  <= outstanding - CW'(imem_rsp_vld);
                count <= '0;
                q_wr  <= '0;
                q_rd  <= '0;
            end else begin
                if (req_hsk) begin
                    pc <= pc + 32'd4;
                end
                if (imem_rsp_vld && (drop != '0)) begin
                    drop <= drop - 1'b1;
                end
                if (push) begin
                    q_wr <= q_wr + 1'b1;
                end
                if (pop) begin
                    q_rd <= q_rd + 1'b1;
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_hsk) begin
            f_pc[f_wr] <= pc;
        end
        if (push && !redir_vld) begin
            q_ir[q_wr] <= imem_rsp_data;
            q_pc[q_wr] <= f_pc[f_rd];
        end
    end

    a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_vld |-> (outstanding != '0));
    a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
        credit_sum <= (CW+1)'(DEPTH));

endmodule
